// File: rtl/shift_seq_pkg.sv
// Shared constants and state encoding for the initial shift sequencer.
package shift_seq_pkg;

  localparam int unsigned LAST_WORD       = 552;
  localparam int unsigned MID_WORD        = 551;
  localparam int unsigned TAIL_BITS       = 5;
  localparam int unsigned ACC_SHIFT_IDX_W = 5;
  localparam int unsigned SHIFT_W         = 16;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StRd0   = 3'd1;
  localparam state_t StRd1   = 3'd2;
  localparam state_t StRd2   = 3'd3;
  localparam state_t StLast  = 3'd4;
  localparam state_t StStart = 3'd5;
  localparam state_t StWait  = 3'd6;
  localparam state_t StWrite = 3'd7;

endpackage

// File: rtl/shift_seq_watchdog.sv
// Cycle counter for the WAIT state; expired is high on the last allowed cycle.
module shift_seq_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = count_en && (cnt_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/initial_shift_sequencer.sv
// Fetches normal words 0/551/552 and one accumulator word, runs the initial shift
// processor, and writes its result back. Optional watchdog: INITIAL_SHIFT_SEQ_TIMEOUT_EN.
module initial_shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [SHIFT_W-1:0]         cmd_shift,
  input  logic [ACC_SHIFT_IDX_W-1:0] cmd_shift_idx,
  input  logic [ADDR_WIDTH-1:0]      cmd_acc_addr,
  output logic                       nrm_rd_en,
  output logic [ADDR_WIDTH-1:0]      nrm_rd_addr,
  input  logic [WORD_WIDTH-1:0]      nrm_rd_data,
  output logic                       acc_rd_en,
  output logic [ADDR_WIDTH-1:0]      acc_rd_addr,
  input  logic [WORD_WIDTH-1:0]      acc_rd_data,
  output logic                       acc_wr_en,
  output logic [ADDR_WIDTH-1:0]      acc_wr_addr,
  output logic [WORD_WIDTH-1:0]      acc_wr_data,
  output logic [WORD_WIDTH-1:0]      normal_word_zero,
  output logic [WORD_WIDTH-1:0]      normal_word_551,
  output logic [WORD_WIDTH-1:0]      normal_word_552,
  output logic [WORD_WIDTH-1:0]      acc_word_i,
  output logic [SHIFT_W-1:0]         shift,
  output logic [ACC_SHIFT_IDX_W-1:0] acc_shift_idx,
  output logic                       start_process,
  input  logic [WORD_WIDTH-1:0]      result,
  input  logic                       processing_done,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  state_t                     state_q, state_d;
  logic [SHIFT_W-1:0]         shift_q;
  logic [ACC_SHIFT_IDX_W-1:0] idx_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [ADDR_WIDTH-1:0]      nrm_addr_q;
  logic [WORD_WIDTH-1:0]      nw0_q, nw551_q, nw552_q, acc_q, result_q;
  logic                       addr_bad;
  logic                       accept;
  logic                       reject;
  logic                       wd_expired;
  logic                       err_to_q;

  assign addr_bad = 32'(cmd_acc_addr) > LAST_WORD;

`ifdef INITIAL_SHIFT_SEQ_TIMEOUT_EN
  shift_seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != StWait),
    .count_en(state_q == StWait),
    .expired (wd_expired)
  );

  // Registered so the abort pulse lands in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= (state_q == StWait) && !processing_done && wd_expired;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign err_to_q   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (addr_bad) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = StRd0;
          end
        end
      end
      StRd0:   state_d = StRd1;
      StRd1:   state_d = StRd2;
      StRd2:   state_d = StLast;
      StLast:  state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (processing_done) begin
          state_d = StWrite;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      nrm_addr_q <= '0;
      nw0_q      <= '0;
      nw551_q    <= '0;
      nw552_q    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shift_q    <= cmd_shift;
        idx_q      <= cmd_shift_idx;
        addr_q     <= cmd_acc_addr;
        nrm_addr_q <= '0;
      end
      // Read data arrives one cycle after its address, so each capture trails its read.
      if (state_q == StRd0) begin
        nrm_addr_q <= ADDR_WIDTH'(MID_WORD);
      end
      if (state_q == StRd1) begin
        nrm_addr_q <= ADDR_WIDTH'(LAST_WORD);
        nw0_q      <= nrm_rd_data;
        acc_q      <= acc_rd_data;
      end
      if (state_q == StRd2) begin
        nw551_q <= nrm_rd_data;
      end
      if (state_q == StLast) begin
        nw552_q <= nrm_rd_data;
      end
      if (state_q == StWait && processing_done) begin
        result_q <= result;
      end
    end
  end

  assign cmd_ready        = (state_q == StIdle);
  assign busy             = (state_q != StIdle);
  assign nrm_rd_en        = (state_q == StRd0) || (state_q == StRd1) || (state_q == StRd2);
  assign nrm_rd_addr      = nrm_addr_q;
  assign acc_rd_en        = (state_q == StRd0);
  assign acc_rd_addr      = addr_q;
  assign acc_wr_en        = (state_q == StWrite);
  assign acc_wr_addr      = addr_q;
  assign acc_wr_data      = result_q;
  assign done             = (state_q == StWrite);
  assign start_process    = (state_q == StStart);
  assign err              = !rst && (reject || err_to_q);
  assign normal_word_zero = nw0_q;
  assign normal_word_551  = nw551_q;
  assign normal_word_552  = nw552_q;
  assign acc_word_i       = acc_q;
  assign shift            = shift_q;
  assign acc_shift_idx    = idx_q;

endmodule

// File: tb/tb_initial_shift_sequencer.sv
// Self-checking bench: RAM and processor models plus a write-back scoreboard.
module tb_initial_shift_sequencer;

  localparam int unsigned WW = 32;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [15:0]   cmd_shift = '0;
  logic [4:0]    cmd_shift_idx = '0;
  logic [AW-1:0] cmd_acc_addr = '0;
  logic          nrm_rd_en, acc_rd_en, acc_wr_en;
  logic [AW-1:0] nrm_rd_addr, acc_rd_addr, acc_wr_addr;
  logic [WW-1:0] nrm_rd_data = '0, acc_rd_data = '0, acc_wr_data;
  logic [WW-1:0] normal_word_zero, normal_word_551, normal_word_552, acc_word_i;
  logic [15:0]   shift;
  logic [4:0]    acc_shift_idx;
  logic          start_process, busy, done, err;
  logic [WW-1:0] result;
  logic          processing_done;

  initial_shift_sequencer #(
    .WORD_WIDTH    (WW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_shift       (cmd_shift),
    .cmd_shift_idx   (cmd_shift_idx),
    .cmd_acc_addr    (cmd_acc_addr),
    .nrm_rd_en       (nrm_rd_en),
    .nrm_rd_addr     (nrm_rd_addr),
    .nrm_rd_data     (nrm_rd_data),
    .acc_rd_en       (acc_rd_en),
    .acc_rd_addr     (acc_rd_addr),
    .acc_rd_data     (acc_rd_data),
    .acc_wr_en       (acc_wr_en),
    .acc_wr_addr     (acc_wr_addr),
    .acc_wr_data     (acc_wr_data),
    .normal_word_zero(normal_word_zero),
    .normal_word_551 (normal_word_551),
    .normal_word_552 (normal_word_552),
    .acc_word_i      (acc_word_i),
    .shift           (shift),
    .acc_shift_idx   (acc_shift_idx),
    .start_process   (start_process),
    .result          (result),
    .processing_done (processing_done),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  logic [WW-1:0] nrm_mem [1024];
  logic [WW-1:0] acc_mem [1024];

  always @(posedge clk) begin
    if (nrm_rd_en) nrm_rd_data <= nrm_mem[nrm_rd_addr];
    if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
  end

  // Arbitrary reference processor: result is a mix of every operand.
  function automatic logic [31:0] proc_fn(input logic [31:0] w0, input logic [31:0] w551,
                                          input logic [31:0] w552, input logic [31:0] acc,
                                          input logic [15:0] sh, input logic [4:0] idx);
    return (acc + ((w0 >> idx) ^ w551)) ^ {w552[4:0], 11'd0, sh};
  endfunction

  // Processor model: done three cycles after start, async active-low reset.
  logic          rst_n;
  logic          proc_en = 1'b1;
  logic [WW-1:0] pres;
  int            pcnt;
  assign rst_n = ~rst;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt            <= 0;
      processing_done <= 1'b0;
      result          <= '0;
      pres            <= '0;
    end else begin
      processing_done <= 1'b0;
      if (start_process && proc_en) begin
        pres <= proc_fn(normal_word_zero, normal_word_551, normal_word_552, acc_word_i,
                        shift, acc_shift_idx);
        pcnt <= 2;
      end else if (pcnt != 0) begin
        pcnt <= pcnt - 1;
        if (pcnt == 1) begin
          processing_done <= 1'b1;
          result          <= pres;
        end
      end
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];

  always @(negedge clk) begin : wr_monitor
    exp_t e;
    if (acc_wr_en === 1'b1 || done === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: wr_en=%0b done=%0b addr=%0d data=%h cyc=%0d, need none",
                 acc_wr_en, done, acc_wr_addr, acc_wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (acc_wr_addr !== e.addr || acc_wr_data !== e.data || cyc != e.cyc ||
            acc_wr_en !== 1'b1 || done !== 1'b1) begin
          $display("FAIL write: addr=%0d data=%h cyc=%0d en=%0b done=%0b, need %0d %h %0d 1 1",
                   acc_wr_addr, acc_wr_data, cyc, acc_wr_en, done, e.addr, e.data, e.cyc);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Drive a command from a negedge and wait (bounded) for acceptance; t = accept cycle or -1.
  task automatic send_cmd(input logic [15:0] sh, input logic [4:0] idx, input logic [AW-1:0] addr,
                          input bit keep, input bit expect_wr, output int t);
    exp_t e;
    cmd_valid     = 1'b1;
    cmd_shift     = sh;
    cmd_shift_idx = idx;
    cmd_acc_addr  = addr;
    t = -1;
    for (int i = 0; i < 64; i++) begin
      if (cmd_ready === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t >= 0) begin
      if (expect_wr) begin
        e.addr = addr;
        e.data = proc_fn(nrm_mem[0], nrm_mem[551], nrm_mem[552], acc_mem[addr], sh, idx);
        e.cyc  = t + 9;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    if (!keep) cmd_valid = 1'b0;
  endtask

  function automatic logic any_out();
    return |{busy, nrm_rd_en, acc_rd_en, acc_wr_en, done, err, start_process, nrm_rd_addr,
             acc_rd_addr, acc_wr_addr, acc_wr_data, normal_word_zero, normal_word_551,
             normal_word_552, acc_word_i, shift, acc_shift_idx};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (any_out() !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL reset_outputs: any_out=%0b cmd_ready=%0b, need 0 and 1", any_out(), cmd_ready);
    end else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL post_reset_idle: cmd_ready=%0b busy=%0b, need 1 0", cmd_ready, busy);
    end else n_pass++;
  endtask

  task automatic test_single();
    int t;
    nrm_mem[0]   = 32'hFFFF_FFFF;
    nrm_mem[551] = 32'h0000_0000;
    nrm_mem[552] = 32'h0000_001F;
    acc_mem[7]   = 32'hA5A5_A5A5;
    send_cmd(16'h0003, 5'd3, 10'd7, 1'b0, 1'b1, t);
    n_total++;
    if (t < 0) $display("FAIL single_accept: no cmd_ready within bound, need accept");
    else n_pass++;
    // Now in cycle T+1.
    n_total++;
    if (nrm_rd_en !== 1'b1 || nrm_rd_addr !== 10'd0 || acc_rd_en !== 1'b1 ||
        acc_rd_addr !== 10'd7 || busy !== 1'b1) begin
      $display("FAIL rd0: nrm_en=%0b nrm_addr=%0d acc_en=%0b acc_addr=%0d busy=%0b, need 1 0 1 7 1",
               nrm_rd_en, nrm_rd_addr, acc_rd_en, acc_rd_addr, busy);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (nrm_rd_en !== 1'b1 || nrm_rd_addr !== 10'd551 || acc_rd_en !== 1'b0) begin
      $display("FAIL rd1: nrm_en=%0b nrm_addr=%0d acc_en=%0b, need 1 551 0",
               nrm_rd_en, nrm_rd_addr, acc_rd_en);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (nrm_rd_en !== 1'b1 || nrm_rd_addr !== 10'd552) begin
      $display("FAIL rd2: nrm_en=%0b nrm_addr=%0d, need 1 552", nrm_rd_en, nrm_rd_addr);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (nrm_rd_en !== 1'b0 || start_process !== 1'b0 || nrm_rd_addr !== 10'd552) begin
      $display("FAIL last: nrm_en=%0b start=%0b nrm_addr=%0d, need 0 0 552",
               nrm_rd_en, start_process, nrm_rd_addr);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (start_process !== 1'b1 || normal_word_zero !== 32'hFFFF_FFFF ||
        normal_word_551 !== 32'h0 || normal_word_552 !== 32'h1F ||
        acc_word_i !== 32'hA5A5_A5A5 || shift !== 16'h0003 || acc_shift_idx !== 5'd3) begin
      $display("FAIL start_operands: start=%0b w0=%h w551=%h w552=%h acc=%h sh=%h idx=%0d, need 1 ffffffff 0 1f a5a5a5a5 0003 3",
               start_process, normal_word_zero, normal_word_551, normal_word_552,
               acc_word_i, shift, acc_shift_idx);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (start_process !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL start_pulse_width: start=%0b busy=%0b, need 0 1", start_process, busy);
    end else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1 || exp_q.size() != 0 || shift !== 16'h0003 ||
        acc_word_i !== 32'hA5A5_A5A5) begin
      $display("FAIL single_end: cmd_ready=%0b pending=%0d sh=%h acc=%h, need 1 0 0003 a5a5a5a5",
               cmd_ready, exp_q.size(), shift, acc_word_i);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    acc_mem[0]   = 32'h1357_9BDF;
    acc_mem[552] = 32'h0F0F_F0F0;
    send_cmd(16'h1234, 5'd7, 10'd0, 1'b1, 1'b1, t1);
    send_cmd(16'hBEEF, 5'd31, 10'd552, 1'b0, 1'b1, t2);
    n_total++;
    if (t1 < 0 || t2 != t1 + 10) begin
      $display("FAIL b2b_accept: t1=%0d t2=%0d, need t2=t1+10", t1, t2);
    end else n_pass++;
    repeat (9) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0 || cmd_ready !== 1'b1) begin
      $display("FAIL b2b_drain: pending=%0d cmd_ready=%0b, need 0 1", exp_q.size(), cmd_ready);
    end else n_pass++;
  endtask

  task automatic test_bad_addr();
    bit rd_seen;
    cmd_valid    = 1'b1;
    cmd_acc_addr = 10'd553;
    #1;
    n_total++;
    if (err !== 1'b1 || cmd_ready !== 1'b1) begin
      $display("FAIL bad_addr_err: err=%0b cmd_ready=%0b, need 1 1", err, cmd_ready);
    end else n_pass++;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_total++;
    if (err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL bad_addr_idle: err=%0b busy=%0b cmd_ready=%0b, need 0 0 1",
               err, busy, cmd_ready);
    end else n_pass++;
    rd_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (nrm_rd_en !== 1'b0 || acc_rd_en !== 1'b0 || busy !== 1'b0) rd_seen = 1'b1;
    end
    n_total++;
    if (rd_seen) $display("FAIL bad_addr_reads: read or busy seen=1, need 0");
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int  t;
    bit  wr_seen;
    send_cmd(16'h0005, 5'd1, 10'd9, 1'b0, 1'b1, t);
    repeat (5) @(negedge clk);
    // Cycle T+6: abort the command.
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_total++;
    if (t < 0 || any_out() !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL mid_reset_outputs: t=%0d any_out=%0b cmd_ready=%0b, need accept 0 1",
               t, any_out(), cmd_ready);
    end else n_pass++;
    rst = 1'b0;
    wr_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (acc_wr_en !== 1'b0 || done !== 1'b0) wr_seen = 1'b1;
    end
    n_total++;
    if (wr_seen) $display("FAIL mid_reset_nowrite: write or done seen=1, need 0");
    else n_pass++;
    acc_mem[12] = 32'hDEAD_0001;
    send_cmd(16'h00F0, 5'd16, 10'd12, 1'b0, 1'b1, t);
    repeat (9) @(negedge clk);
    n_total++;
    if (t < 0 || exp_q.size() != 0 || cmd_ready !== 1'b1) begin
      $display("FAIL mid_reset_recover: t=%0d pending=%0d cmd_ready=%0b, need accept 0 1",
               t, exp_q.size(), cmd_ready);
    end else n_pass++;
  endtask

  task automatic test_timeout();
    int t;
    int ecyc;
    proc_en = 1'b0;
    send_cmd(16'h0101, 5'd2, 10'd3, 1'b0, 1'b0, t);
`ifdef INITIAL_SHIFT_SEQ_TIMEOUT_EN
    ecyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (err === 1'b1) begin
        ecyc = cyc;
        break;
      end
      @(negedge clk);
    end
    n_total++;
    if (t < 0 || ecyc != t + 22 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL timeout_err: t=%0d err_cyc=%0d busy=%0b ready=%0b, need err at t+22 0 1",
               t, ecyc, busy, cmd_ready);
    end else n_pass++;
    @(negedge clk);
`else
    ecyc = t + 30;
    while (cyc < ecyc) @(negedge clk);
    n_total++;
    if (t < 0 || busy !== 1'b1 || err !== 1'b0) begin
      $display("FAIL wait_forever: t=%0d busy=%0b err=%0b, need accept 1 0", t, busy, err);
    end else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    proc_en = 1'b1;
    n_total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      $display("FAIL timeout_end: pending=%0d busy=%0b, need 0 0", exp_q.size(), busy);
    end else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      nrm_mem[i] = $urandom;
      acc_mem[i] = $urandom;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_addr();
    test_mid_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, need finish", $time);
    $fatal(1, "bench time limit");
  end

endmodule
